// File: rtl/clks_alot_p.sv
// Shared types for the lease scheduler: widths, FSM state encoding, latched lease
// configuration and the zero-rate clamp helper.
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH = 8;
    localparam int LEASE_WIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0] high;
        logic [RATE_COUNTER_WIDTH-1:0] low;
        logic                          pol;
        logic [LEASE_WIDTH-1:0]        lease;
    } lease_cfg_s;

    localparam lease_cfg_s CFG_RST = '{
        high:  RATE_COUNTER_WIDTH'(1),
        low:   RATE_COUNTER_WIDTH'(1),
        pol:   1'b0,
        lease: {LEASE_WIDTH{1'b0}}
    };

    // A zero rate would stall the generator, so it is run as the fastest legal rate.
    function automatic logic [RATE_COUNTER_WIDTH-1:0] clamp_rate(
        input logic [RATE_COUNTER_WIDTH-1:0] rate
    );
        return (rate == {RATE_COUNTER_WIDTH{1'b0}}) ? RATE_COUNTER_WIDTH'(1) : rate;
    endfunction

endpackage

// File: rtl/clks_alot_rr_arbiter.sv
// Rotating-priority picker: one-hot grant plus index; the pointer moves to the
// requester after the winner whenever adv_i accepts the grant.
module clks_alot_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Scan from the pointer upward, wrapping, and take the first active request.
    always_comb begin
        gnt_o   = {N{1'b0}};
        idx_o   = {IW{1'b0}};
        found_s = 1'b0;
        cand_s  = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr_q) + k) % N);
            if (!found_s && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer position.
    always_comb begin
        if (adv_i) begin
            ptr_d = IW'((int'(idx_o) + 1) % N);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q <= {IW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/clkgen_lease_sched.sv
// Leases one test-clock generator to REQ_COUNT requesters for a counted number of periods.
// Optional RUN-state watchdog: define CLKGEN_SCHED_WATCHDOG_EN.
module clkgen_lease_sched
    import clks_alot_p::*;
#(
    parameter  int REQ_COUNT = 4,
    parameter  int RATE_W    = RATE_COUNTER_WIDTH,
    parameter  int LEASE_W   = LEASE_WIDTH,
    localparam int IDX_W     = $clog2(REQ_COUNT)
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         clk_en_i,
    input  logic [REQ_COUNT-1:0]         req_valid_i,
    output logic [REQ_COUNT-1:0]         req_ready_o,
    input  logic [REQ_COUNT*RATE_W-1:0]  req_high_i,
    input  logic [REQ_COUNT*RATE_W-1:0]  req_low_i,
    input  logic [REQ_COUNT-1:0]         req_pol_i,
    input  logic [REQ_COUNT*LEASE_W-1:0] req_lease_i,
    input  logic                         abort_i,
    input  logic                         gen_clk_i,
    output logic                         gen_init_o,
    output logic                         gen_en_o,
    output logic                         gen_pol_o,
    output logic [RATE_W-1:0]            gen_high_o,
    output logic [RATE_W-1:0]            gen_low_o,
    output logic [REQ_COUNT-1:0]         owner_o,
    output logic                         done_o,
    output logic [IDX_W-1:0]             done_id_o,
    output logic                         done_abort_o
);

    sched_state_e         state_q;
    lease_cfg_s           cfg_q;
    lease_cfg_s           sel_cfg_s;
    logic [REQ_COUNT-1:0] owner_q;
    logic [REQ_COUNT-1:0] arb_gnt_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     done_id_q;
    logic [LEASE_W-1:0]   cnt_q;
    logic [LEASE_W-1:0]   cnt_inc_s;
    logic                 gclk_q;
    logic                 init_q;
    logic                 en_q;
    logic                 done_q;
    logic                 done_abort_q;
    logic                 grant_s;
    logic                 period_s;
    logic                 final_s;
    logic                 wd_trip_s;
    logic                 end_s;
    logic                 end_abort_s;

    assign grant_s     = clk_en_i && (state_q == IDLE) && (|req_valid_i);
    assign req_ready_o = grant_s ? arb_gnt_s : {REQ_COUNT{1'b0}};

    clks_alot_rr_arbiter #(.N(REQ_COUNT)) u_arb (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .req_i    (req_valid_i),
        .adv_i    (grant_s),
        .gnt_o    (arb_gnt_s),
        .idx_o    (arb_idx_s)
    );

    // Configuration of the requester the arbiter currently favours.
    always_comb begin
        sel_cfg_s       = CFG_RST;
        sel_cfg_s.high  = clamp_rate(req_high_i[arb_idx_s*RATE_W +: RATE_W]);
        sel_cfg_s.low   = clamp_rate(req_low_i[arb_idx_s*RATE_W +: RATE_W]);
        sel_cfg_s.pol   = req_pol_i[arb_idx_s];
        sel_cfg_s.lease = req_lease_i[arb_idx_s*LEASE_W +: LEASE_W];
    end

    // A period completes when the sampled generator output returns to the start polarity.
    assign period_s  = (state_q == RUN) && (gen_clk_i == cfg_q.pol) && (gclk_q != cfg_q.pol);
    assign cnt_inc_s = cnt_q + LEASE_W'(1);
    assign final_s   = period_s && (cnt_inc_s == cfg_q.lease);

`ifdef CLKGEN_SCHED_WATCHDOG_EN
    localparam int WD_W = RATE_W + 2;
    logic [WD_W-1:0] wd_q;
    logic [WD_W:0]   wd_limit_s;

    assign wd_limit_s = (((WD_W+1)'(cfg_q.high) + (WD_W+1)'(cfg_q.low)) << 1) + (WD_W+1)'(4);
    assign wd_trip_s  = (state_q == RUN) && !period_s &&
                        (({1'b0, wd_q} + (WD_W+1)'(1)) >= wd_limit_s);

    // Saturating idle-cycle counter, reloaded on each counted period.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wd_q <= {WD_W{1'b0}};
        end else if (clk_en_i) begin
            if ((state_q != RUN) || period_s) begin
                wd_q <= {WD_W{1'b0}};
            end else if (wd_q != {WD_W{1'b1}}) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= wd_q;
            end
        end
    end
`else
    assign wd_trip_s = 1'b0;
`endif

    // Lease termination: completion outranks abort when both land in the same cycle.
    always_comb begin
        end_s       = 1'b0;
        end_abort_s = 1'b0;
        case (state_q)
            LOAD: begin
                end_s       = abort_i || (cfg_q.lease == {LEASE_W{1'b0}});
                end_abort_s = abort_i;
            end
            RUN: begin
                end_s       = final_s || abort_i || wd_trip_s;
                end_abort_s = !final_s && (abort_i || wd_trip_s);
            end
            default: begin
                end_s       = 1'b0;
                end_abort_s = 1'b0;
            end
        endcase
    end

    // Lease sequencer with registered generator controls.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            cfg_q        <= CFG_RST;
            owner_q      <= {REQ_COUNT{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            done_id_q    <= {IDX_W{1'b0}};
            cnt_q        <= {LEASE_W{1'b0}};
            gclk_q       <= 1'b0;
            init_q       <= 1'b0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
            done_abort_q <= 1'b0;
        end else if (clk_en_i) begin
            gclk_q       <= gen_clk_i;
            init_q       <= 1'b0;
            done_q       <= 1'b0;
            done_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        cfg_q   <= sel_cfg_s;
                        owner_q <= arb_gnt_s;
                        idx_q   <= arb_idx_s;
                        init_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    cnt_q   <= {LEASE_W{1'b0}};
                    en_q    <= !end_s;
                    state_q <= end_s ? DONE : RUN;
                end
                RUN: begin
                    if (period_s) begin
                        cnt_q <= cnt_inc_s;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                    if (end_s) begin
                        en_q    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            if (end_s) begin
                done_q       <= 1'b1;
                done_abort_q <= end_abort_s;
                done_id_q    <= idx_q;
                owner_q      <= {REQ_COUNT{1'b0}};
            end
        end
    end

    assign gen_init_o   = init_q;
    assign gen_en_o     = en_q;
    assign gen_pol_o    = cfg_q.pol;
    assign gen_high_o   = cfg_q.high;
    assign gen_low_o    = cfg_q.low;
    assign owner_o      = owner_q;
    assign done_o       = done_q;
    assign done_id_o    = done_id_q;
    assign done_abort_o = done_abort_q;

endmodule

// File: tb/tb_clkgen_lease_sched.sv
// Scoreboard bench for clkgen_lease_sched with a behavioural clock-generator model.
`timescale 1ns/1ps
module tb_clkgen_lease_sched;
    import clks_alot_p::*;

    localparam int N  = 4;
    localparam int RW = RATE_COUNTER_WIDTH;
    localparam int LW = LEASE_WIDTH;
    localparam int IW = 2;

    logic clk = 1'b0, arst_n = 1'b0, clk_en = 1'b1, abort = 1'b0, gen_clk = 1'b0;
    logic [N-1:0]    req_valid = '0, req_pol = '0;
    logic [N-1:0]    req_ready, owner;
    logic [N*RW-1:0] req_high = '0, req_low = '0;
    logic [N*LW-1:0] req_lease = '0;
    logic            gen_init, gen_en, gen_pol, done, done_abort;
    logic [RW-1:0]   gen_high, gen_low;
    logic [IW-1:0]   done_id;

    typedef struct { int id; bit abort; int lease; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   grant_log[$];
    int   errors = 0, checks = 0;
    bit   plan_abort = 1'b0, tie0 = 1'b0, en_seen = 1'b0;
    int   periods = 0, gcnt = 0, run_cycles = 0;

    clkgen_lease_sched dut (
        .clk_i(clk), .arst_n_i(arst_n), .clk_en_i(clk_en),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_high_i(req_high), .req_low_i(req_low), .req_pol_i(req_pol), .req_lease_i(req_lease),
        .abort_i(abort), .gen_clk_i(gen_clk),
        .gen_init_o(gen_init), .gen_en_o(gen_en), .gen_pol_o(gen_pol),
        .gen_high_o(gen_high), .gen_low_o(gen_low), .owner_o(owner),
        .done_o(done), .done_id_o(done_id), .done_abort_o(done_abort)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator model: starts at pol on init, holds each level for its rate while enabled.
    always @(negedge clk) begin
        if (!arst_n) begin
            gen_clk = 1'b0; gcnt = 0; periods = 0;
        end else if (clk_en) begin
            if (tie0) begin
                gen_clk = 1'b0;
            end else if (gen_init) begin
                gen_clk = gen_pol; gcnt = 0; periods = 0;
            end else if (gen_en) begin
                gcnt++;
                if (gcnt >= int'(gen_clk ? gen_high : gen_low)) begin
                    gen_clk = ~gen_clk; gcnt = 0;
                    if (gen_clk == gen_pol) periods++;
                end
            end
        end
    end

    // Monitor: push on handshake, pop and compare on done.
    always @(negedge clk) begin
        if (arst_n && clk_en) begin
            if (gen_en) begin en_seen = 1'b1; run_cycles++; end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, plan_abort, int'(req_lease[i*LW +: LW])});
                    grant_log.push_back(i);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("done_id", 32'(done_id), 32'(mon_e.id));
                    check_eq("done_abort", 32'(done_abort), 32'(mon_e.abort));
                    if (!mon_e.abort) check_eq("periods", 32'(periods), 32'(mon_e.lease));
                end
            end
        end
    end

    task automatic set_req(input int i, input int h, input int l, input bit p, input int ls);
        req_high[i*RW +: RW]  = RW'(h);
        req_low[i*RW +: RW]   = RW'(l);
        req_pol[i]            = p;
        req_lease[i*LW +: LW] = LW'(ls);
    endtask

    // Raise valid for one cycle, check the combinational grant, then drop it after the edge.
    task automatic request(input string tag, input logic [N-1:0] mask, input logic [N-1:0] exp_rdy);
        req_valid = mask;
        @(negedge clk);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || owner != '0 || done) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_no_timeout"}, 32'(n < budget), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_init"},  32'(gen_init), 32'd0);
        check_eq({tag, "_en"},    32'(gen_en), 32'd0);
        check_eq({tag, "_pol"},   32'(gen_pol), 32'd0);
        check_eq({tag, "_high"},  32'(gen_high), 32'd1);
        check_eq({tag, "_low"},   32'(gen_low), 32'd1);
        check_eq({tag, "_owner"}, 32'(owner), 32'd0);
        check_eq({tag, "_done"},  32'({done, done_abort, done_id}), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin from reset: all valid, lease 1
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 1'b0, 1);
        grant_log.delete();
        req_valid = 4'hF;
        for (int n = 0; n < 200 && grant_log.size() < 5; n++) begin
            @(posedge clk); #1;
        end
        req_valid = '0;
        check_eq("rr_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check_eq("rr_order", 32'(grant_log[i]), 32'(i % N));
        wait_quiet("rr", 200);

        // Basic lease on req0
        set_req(0, 2, 3, 1'b0, 4);
        request("basic", 4'b0001, 4'b0001);
        check_eq("basic_init", 32'(gen_init), 32'd1);
        check_eq("basic_owner", 32'(owner), 32'd1);
        check_eq("basic_cfg", 32'({gen_high, gen_low, gen_pol}), 32'({8'd2, 8'd3, 1'b0}));
        wait_quiet("basic", 200);

        // Zero-length lease on req2
        set_req(2, 2, 2, 1'b0, 0);
        en_seen = 1'b0;
        request("zero", 4'b0100, 4'b0100);
        @(posedge clk); #1;
        check_eq("zero_done", 32'({done, done_abort}), 32'b10);
        wait_quiet("zero", 50);
        check_eq("zero_no_en", 32'(en_seen), 32'd0);

        // Zero rates clamp to 1
        set_req(1, 0, 0, 1'b1, 3);
        request("clamp", 4'b0010, 4'b0010);
        @(posedge clk); #1;
        check_eq("clamp_rates", 32'({gen_en, gen_high, gen_low, gen_pol}), 32'({1'b1, 8'd1, 8'd1, 1'b1}));
        wait_quiet("clamp", 100);

        // Abort mid-run
        set_req(3, 2, 2, 1'b0, 100);
        plan_abort = 1'b1;
        request("abort", 4'b1000, 4'b1000);
        plan_abort = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_en_fall", 32'({gen_en, done, done_abort}), 32'b011);
        wait_quiet("abort", 50);

        // Abort coinciding with the final period: completion wins
        set_req(0, 1, 1, 1'b0, 2);
        request("coinc", 4'b0001, 4'b0001);
        for (int n = 0; n < 50 && periods != 2; n++) begin
            @(negedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("coinc_done", 32'({done, done_abort}), 32'b10);
        wait_quiet("coinc", 50);

        // Clock enable low for 10 cycles mid-run
        set_req(0, 3, 3, 1'b0, 5);
        request("freeze", 4'b0001, 4'b0001);
        repeat (8) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check_eq("freeze_outputs",
                     32'({owner, gen_en, gen_init, done, gen_pol, gen_high, gen_low, req_ready}),
                     32'({4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 4'b0000}));
        end
        clk_en = 1'b1;
        wait_quiet("freeze", 200);

        // Async reset mid-run, then pointer restarts at requester 0
        set_req(1, 4, 4, 1'b0, 50);
        request("arst", 4'b0010, 4'b0010);
        repeat (5) @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        sb.delete();
        @(posedge clk); #1;
        arst_n = 1'b1;
        set_req(0, 1, 1, 1'b0, 1);
        set_req(2, 1, 1, 1'b0, 1);
        request("post_rst", 4'b0101, 4'b0001);
        wait_quiet("post_rst", 50);

`ifdef CLKGEN_SCHED_WATCHDOG_EN
        // Stuck generator trips the watchdog
        tie0 = 1'b1;
        set_req(0, 2, 2, 1'b0, 5);
        plan_abort = 1'b1;
        run_cycles = 0;
        request("wd", 4'b0001, 4'b0001);
        plan_abort = 1'b0;
        wait_quiet("wd", 100);
        check_eq("wd_run_cycles", 32'(run_cycles), 32'd12);
        tie0 = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
